// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the VGA sync generator to the tile/colour renderer.
// The generator drives everything; the renderer only observes.
interface vga_sync_gen_if;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;

    modport master (
        output pix_en,
        output hsync,
        output vsync,
        output video_on,
        output x,
        output y,
        output frame_start
    );

    modport slave (
        input pix_en,
        input hsync,
        input vsync,
        input video_on,
        input x,
        input y,
        input frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: a prescaler makes a pixel-rate enable from the system clock,
// and x/y counters plus registered sync/video decode follow that enable.
module vga_sync_gen #(
    parameter int DIV_LOG2  = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic           clk,
    input  logic           clr,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);

    // A zero-width prescaler is not legal, so DIV_LOG2 == 0 keeps one bit pinned at zero.
    localparam int            PW   = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
    localparam logic [PW-1:0] PMAX = PW'((1 << DIV_LOG2) - 1);

    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_next;
    logic [9:0]    x_next;
    logic [9:0]    y_next;
    logic          wrap;

    always_comb begin
        prescaler_next = (prescaler == PMAX) ? '0 : prescaler + 1'b1;
        x_next         = vga.x;
        y_next         = vga.y;
        wrap           = 1'b0;
        if (vga.pix_en) begin
            if (vga.x == X_LAST) begin
                x_next = '0;
                if (vga.y == Y_LAST) begin
                    y_next = '0;
                    wrap   = 1'b1;
                end else begin
                    y_next = vga.y + 10'd1;
                end
            end else begin
                x_next = vga.x + 10'd1;
            end
        end
    end

    // Decode from the next counter values so the registered flags line up with x/y.
    always_ff @(posedge clk) begin
        if (clr) begin
            prescaler       <= '0;
            vga.pix_en      <= 1'b0;
            vga.x           <= '0;
            vga.y           <= '0;
            vga.hsync       <= 1'b1;
            vga.vsync       <= 1'b1;
            vga.video_on    <= 1'b1;
            vga.frame_start <= 1'b0;
        end else begin
            prescaler       <= prescaler_next;
            vga.pix_en      <= (prescaler_next == PMAX);
            vga.x           <= x_next;
            vga.y           <= y_next;
            vga.hsync       <= !((x_next >= H_SYNC_BEG) && (x_next < H_SYNC_END));
            vga.vsync       <= !((y_next >= V_SYNC_BEG) && (y_next < V_SYNC_END));
            vga.video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
            vga.frame_start <= wrap;
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomised-reset scoreboard bench for vga_sync_gen: three configurations share one reset and
// are checked every cycle against a pixel-index model derived from the cycle count since release.
module tb_vga_sync_gen;
    logic clk;
    logic clr;

    typedef struct {
        logic pix_en;
        logic hsync;
        logic vsync;
        logic video_on;
        logic frame_start;
        int   x;
        int   y;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int k            = 0;

    vga_sync_gen_if bus0();
    vga_sync_gen_if bus1();
    vga_sync_gen_if bus2();

    vga_sync_gen u_dflt (
        .clk (clk),
        .clr (clr),
        .vga (bus0)
    );

    vga_sync_gen #(
        .DIV_LOG2(0), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .clk (clk),
        .clr (clr),
        .vga (bus1)
    );

    vga_sync_gen #(
        .DIV_LOG2(2), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small4 (
        .clk (clk),
        .clr (clr),
        .vga (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic pix_at(int kk, int n);
        return (kk > 0) && ((kk % n) == (n - 1));
    endfunction

    // Cycle kk counts clocks since the reset state; pixel index is the number of enables before it.
    function automatic exp_t model_at(int kk, int n, int hv, int hf, int hs, int hb,
                                      int vv, int vf, int vs, int vb);
        exp_t e;
        int ht, vt, p, pos;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        if (n == 1) p = (kk > 0) ? kk - 1 : 0;
        else        p = kk / n;
        pos = p % (ht * vt);
        e.x           = pos % ht;
        e.y           = pos / ht;
        e.pix_en      = pix_at(kk, n);
        e.hsync       = !((e.x >= hv + hf) && (e.x < hv + hf + hs));
        e.vsync       = !((e.y >= vv + vf) && (e.y < vv + vf + vs));
        e.video_on    = (e.x < hv) && (e.y < vv);
        e.frame_start = (p > 0) && (pos == 0) && pix_at(kk - 1, n);
        return e;
    endfunction

    task automatic applyStimulus(input logic clr_val);
        clr = clr_val;
        if (clr_val) k = 0;
        else         k = k + 1;
        q0.push_back(model_at(k, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        q1.push_back(model_at(k, 1, 4, 1, 2, 1, 2, 1, 1, 1));
        q2.push_back(model_at(k, 4, 4, 1, 2, 1, 2, 1, 1, 1));
    endtask

    task automatic check_field(input string tag, input string field, input int got, input int want);
        tests_run = tests_run + 1;
        if (got != want) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s.%s at %0t: got %0d expected %0d", tag, field, $time, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e, input logic pix_en,
                               input logic hsync, input logic vsync, input logic video_on,
                               input logic frame_start, input logic [9:0] x, input logic [9:0] y);
        check_field(tag, "pix_en",      int'(pix_en),      int'(e.pix_en));
        check_field(tag, "hsync",       int'(hsync),       int'(e.hsync));
        check_field(tag, "vsync",       int'(vsync),       int'(e.vsync));
        check_field(tag, "video_on",    int'(video_on),    int'(e.video_on));
        check_field(tag, "frame_start", int'(frame_start), int'(e.frame_start));
        check_field(tag, "x",           int'(x),           e.x);
        check_field(tag, "y",           int'(y),           e.y);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checkOutput("dflt", e, bus0.pix_en, bus0.hsync, bus0.vsync, bus0.video_on,
                        bus0.frame_start, bus0.x, bus0.y);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput("small", e, bus1.pix_en, bus1.hsync, bus1.vsync, bus1.video_on,
                        bus1.frame_start, bus1.x, bus1.y);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            checkOutput("small4", e, bus2.pix_en, bus2.hsync, bus2.vsync, bus2.video_on,
                        bus2.frame_start, bus2.x, bus2.y);
        end
    end

    initial begin
        int hold;
        logic c;
        hold = 0;
        clr  = 1'b1;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            // A directed reset lands inside the default line's hsync (x = 750).
            if (cyc < 3 || cyc == 3003) begin
                c = 1'b1;
            end else if (hold > 0) begin
                c    = 1'b1;
                hold = hold - 1;
            end else if ($urandom_range(0, 3999) == 0) begin
                c    = 1'b1;
                hold = int'($urandom_range(0, 2));
            end else begin
                c = 1'b0;
            end
            applyStimulus(c);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 10 && (q0.size() + q1.size() + q2.size()) > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if ((q0.size() + q1.size() + q2.size()) > 0) begin
            tests_run    = tests_run + 1;
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL drain: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
